// File: rtl/fltr_tdm_ctrl_pkg.sv
// rtl/fltr_tdm_ctrl_pkg.sv - shared types and helpers for the TDM glitch-filter controller
package fltr_tdm_ctrl_pkg;

    // Default run-counter / threshold width used by the per-channel state record
    localparam int FLTR_CW = 4;
    // Widest channel index the event record can carry (up to 16 channels)
    localparam int FLTR_CH_W_MAX = 4;

    // Per-channel stored filter state (the filtered level lives in the out vector)
    typedef struct packed {
        logic [FLTR_CW-1:0] run;
    } fltr_ch_state_t;

    // Level-change event presented on the event port
    typedef struct packed {
        logic [FLTR_CH_W_MAX-1:0] ch;
        logic                     val;
    } fltr_evt_t;

    // Width of a channel index; never below one bit
    function automatic int fltr_ch_w(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/fltr_step.sv
// rtl/fltr_step.sv - combinational N-consecutive-sample filter update for one channel
module fltr_step #(
    parameter int CW = 4
) (
    input  logic          s_i,
    input  logic          level_i,
    input  logic [CW-1:0] run_i,
    input  logic [CW-1:0] thr_i,
    output logic          level_n_o,
    output logic [CW-1:0] run_n_o,
    output logic          flip_o
);

    // One extra bit so a counter at its maximum still compares correctly
    logic [CW:0] run_inc;
    assign run_inc = {1'b0, run_i} + (CW+1)'(1);

    // Equal sample clears the run; an opposite run reaching thr flips the level
    always_comb begin
        level_n_o = level_i;
        run_n_o   = run_i;
        flip_o    = 1'b0;
        if (s_i == level_i) begin
            run_n_o = '0;
        end else if (run_inc >= {1'b0, thr_i}) begin
            level_n_o = s_i;
            run_n_o   = '0;
            flip_o    = 1'b1;
        end else begin
            run_n_o = run_inc[CW-1:0];
        end
    end

endmodule

// File: rtl/fltr_tdm_ctrl.sv
// rtl/fltr_tdm_ctrl.sv - time-division controller sharing one filter step across CH channels
module fltr_tdm_ctrl
    import fltr_tdm_ctrl_pkg::*;
#(
    parameter int CH = 4,
    parameter int N  = 3,
    parameter int CW = 4,
    localparam int CH_W = fltr_ch_w(CH)
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic [CH-1:0]   in_i,
    output logic [CH-1:0]   out_o,
    input  logic            cfg_we_i,
    input  logic [CW-1:0]   cfg_n_i,
    output logic            cfg_busy_o,
    output logic            frame_done_o,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_val_o,
    output logic            ovf_o
);

    logic [CH_W-1:0] slot_q, slot_d;
    logic [CH-1:0]   out_q, out_d;
    fltr_ch_state_t  st_q [CH];
    fltr_ch_state_t  st_d [CH];
    logic [CW-1:0]   thr_q, thr_d;
    logic [CW-1:0]   cfg_q, cfg_d;
    logic            cfg_busy_q, cfg_busy_d;
    logic            frame_done_q, frame_done_d;
    fltr_evt_t       evt_q, evt_d;
    logic            evt_valid_q, evt_valid_d;
    logic            ovf_q, ovf_d;

    logic            last_slot;
    logic            step_level_n;
    logic [CW-1:0]   step_run_n;
    logic            step_flip;
    logic [CW-1:0]   cfg_n_eff;

    assign last_slot = (slot_q == CH_W'(CH - 1));
    assign cfg_n_eff = (cfg_n_i == '0) ? CW'(1) : cfg_n_i;

    fltr_step #(
        .CW (CW)
    ) u_step (
        .s_i       (in_i[slot_q]),
        .level_i   (out_q[slot_q]),
        .run_i     (CW'(st_q[slot_q].run)),
        .thr_i     (thr_q),
        .level_n_o (step_level_n),
        .run_n_o   (step_run_n),
        .flip_o    (step_flip)
    );

    // Round-robin slot pointer and frame-end pulse
    always_comb begin
        slot_d       = last_slot ? '0 : slot_q + CH_W'(1);
        frame_done_d = last_slot;
    end

    // Write back only the served channel's level and run counter
    always_comb begin
        out_d = out_q;
        st_d  = st_q;
        out_d[slot_q]     = step_level_n;
        st_d[slot_q].run  = FLTR_CW'(step_run_n);
    end

    // Threshold request: apply pending value at frame end, then latch any new write
    always_comb begin
        thr_d      = thr_q;
        cfg_d      = cfg_q;
        cfg_busy_d = cfg_busy_q;
        if (last_slot && cfg_busy_q) begin
            thr_d      = cfg_q;
            cfg_busy_d = 1'b0;
        end
        if (cfg_we_i) begin
            cfg_d      = cfg_n_eff;
            cfg_busy_d = 1'b1;
        end
    end

    // One-deep event register; a flip with no room is dropped and flagged
    always_comb begin
        evt_d       = evt_q;
        evt_valid_d = evt_valid_q & ~evt_ready_i;
        ovf_d       = ovf_q;
        if (step_flip) begin
            if (!evt_valid_q || evt_ready_i) begin
                evt_d.ch    = FLTR_CH_W_MAX'(slot_q);
                evt_d.val   = step_level_n;
                evt_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset_i) begin
            slot_q       <= '0;
            out_q        <= '0;
            st_q         <= '{default: '0};
            thr_q        <= CW'(N);
            cfg_q        <= '0;
            cfg_busy_q   <= 1'b0;
            frame_done_q <= 1'b0;
            evt_q        <= '0;
            evt_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            out_q        <= out_d;
            st_q         <= st_d;
            thr_q        <= thr_d;
            cfg_q        <= cfg_d;
            cfg_busy_q   <= cfg_busy_d;
            frame_done_q <= frame_done_d;
            evt_q        <= evt_d;
            evt_valid_q  <= evt_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign out_o        = out_q;
    assign cfg_busy_o   = cfg_busy_q;
    assign frame_done_o = frame_done_q;
    assign evt_valid_o  = evt_valid_q;
    assign evt_ch_o     = CH_W'(evt_q.ch);
    assign evt_val_o    = evt_q.val;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_fltr_tdm_ctrl.sv
// tb/tb_fltr_tdm_ctrl.sv - scoreboard bench for the TDM glitch-filter controller
module tb_fltr_tdm_ctrl;

    localparam int CH  = 4;
    localparam int N   = 3;
    localparam int CW  = 4;
    localparam int CHW = 2;

    logic           clk;
    logic           reset;
    logic [CH-1:0]  in_s;
    logic [CH-1:0]  out_s;
    logic           cfg_we;
    logic [CW-1:0]  cfg_n;
    logic           cfg_busy;
    logic           frame_done;
    logic           evt_valid;
    logic           evt_ready;
    logic [CHW-1:0] evt_ch;
    logic           evt_val;
    logic           ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int val;
    } exp_evt_t;

    exp_evt_t exp_q[$];

    fltr_tdm_ctrl #(
        .CH (CH),
        .N  (N),
        .CW (CW)
    ) dut (
        .clk          (clk),
        .reset_i      (reset),
        .in_i         (in_s),
        .out_o        (out_s),
        .cfg_we_i     (cfg_we),
        .cfg_n_i      (cfg_n),
        .cfg_busy_o   (cfg_busy),
        .frame_done_o (frame_done),
        .evt_valid_o  (evt_valid),
        .evt_ready_i  (evt_ready),
        .evt_ch_o     (evt_ch),
        .evt_val_o    (evt_val),
        .ovf_o        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] v);
        in_s = v;
        repeat (4) cycle();
    endtask

    task automatic push_evt(input int ch, input int val);
        exp_evt_t e;
        e.ch  = ch;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted event is popped from the scoreboard and compared
    initial begin
        exp_evt_t e;
        forever begin
            @(negedge clk);
            if (!reset && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", int'(evt_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_ch", int'(evt_ch), e.ch);
                    chk("evt_val", int'(evt_val), e.val);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_s      = '0;
        cfg_we    = 1'b0;
        cfg_n     = '0;
        evt_ready = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;

        chk("rst_out", int'(out_s), 0);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_cfg_busy", int'(cfg_busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // Steady high on ch0 flips it at the third slot-0 edge
        frame(4'b0001);
        frame(4'b0001);
        chk("t1_out_before", int'(out_s), 0);
        push_evt(0, 1);
        cycle();
        chk("t1_out_flip", int'(out_s), 1);
        chk("t1_frame_done_mid", int'(frame_done), 0);
        repeat (3) cycle();
        chk("t1_frame_done_end", int'(frame_done), 1);

        // ch1 alternating per slot never accumulates a run
        repeat (3) begin
            frame(4'b0011);
            frame(4'b0001);
        end
        chk("t2_out", int'(out_s), 1);

        // ch2 rises, then a one-slot glitch is rejected, then three lows flip it back
        frame(4'b0101);
        frame(4'b0101);
        push_evt(2, 1);
        frame(4'b0101);
        chk("t3_rise", int'(out_s), 5);
        frame(4'b0001);
        frame(4'b0101);
        chk("t3_glitch", int'(out_s), 5);
        frame(4'b0001);
        frame(4'b0001);
        push_evt(2, 0);
        frame(4'b0001);
        chk("t3_fall", int'(out_s), 1);

        // Two flips in one frame with the consumer stalled: second event dropped
        evt_ready = 1'b0;
        frame(4'b0010);
        frame(4'b0010);
        push_evt(0, 0);
        frame(4'b0010);
        chk("t4_out", int'(out_s), 2);
        chk("t4_ovf", int'(ovf), 1);
        chk("t4_valid", int'(evt_valid), 1);
        repeat (2) cycle();
        chk("t4_hold_valid", int'(evt_valid), 1);
        chk("t4_hold_ch", int'(evt_ch), 0);
        chk("t4_hold_val", int'(evt_val), 0);
        evt_ready = 1'b1;
        cycle();
        chk("t4_valid_drop", int'(evt_valid), 0);
        chk("t4_ovf_sticky", int'(ovf), 1);
        cycle();

        // Threshold 1 requested mid-frame, applied at the slot-3 edge
        cycle();
        cfg_we = 1'b1;
        cfg_n  = 4'd1;
        cycle();
        cfg_we = 1'b0;
        chk("t5_busy_a", int'(cfg_busy), 1);
        cycle();
        chk("t5_busy_b", int'(cfg_busy), 1);
        cycle();
        chk("t5_busy_clear", int'(cfg_busy), 0);
        in_s = 4'b0011;
        push_evt(0, 1);
        cycle();
        chk("t5_thr1_flip", int'(out_s), 3);
        cycle();

        // Write coincident with the apply edge stays pending for one more frame
        cfg_we = 1'b1;
        cfg_n  = 4'd5;
        cycle();
        cfg_n  = 4'd2;
        cycle();
        cfg_we = 1'b0;
        chk("t5_busy_repend", int'(cfg_busy), 1);
        frame(4'b0001);
        chk("t5_thr5_noflip", int'(out_s), 3);
        chk("t5_busy_clear2", int'(cfg_busy), 0);
        push_evt(1, 0);
        frame(4'b0001);
        chk("t5_thr2_flip", int'(out_s), 1);

        // Reset with an event pending, a cfg request pending and out nonzero
        evt_ready = 1'b0;
        frame(4'b0011);
        cycle();
        cfg_we = 1'b1;
        cfg_n  = 4'd7;
        cycle();
        cfg_we = 1'b0;
        chk("t6_pre_valid", int'(evt_valid), 1);
        chk("t6_pre_busy", int'(cfg_busy), 1);
        chk("t6_pre_out", int'(out_s), 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_out", int'(out_s), 0);
        chk("t6_valid", int'(evt_valid), 0);
        chk("t6_busy", int'(cfg_busy), 0);
        chk("t6_ovf", int'(ovf), 0);
        chk("t6_frame_done", int'(frame_done), 0);
        chk("t6_evt_ch", int'(evt_ch), 0);
        chk("t6_evt_val", int'(evt_val), 0);
        evt_ready = 1'b1;
        frame(4'b0001);
        frame(4'b0001);
        chk("t6_thr3_wait", int'(out_s), 0);
        push_evt(0, 1);
        cycle();
        chk("t6_thr3_flip", int'(out_s), 1);
        repeat (4) cycle();

        chk("evt_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
